ghash_mult_seq: RTL and testbench
=================================

// Module: ghash_mult_seq
// PURPOSE
//  Digit-serial GF(2^128) multiplier with an internal GHASH accumulator and valid/ready handshakes.
//  Computes Y_new = (Y_prev ^ X) * H using the GCM bit order.
//  Bit [0] is the MSB and the coefficient of x^0. R = 0xE1 << 120.
//  Generalises the fixed single-shot (i1^i2)*i3 multiplier: digit width is configurable,
//  block chaining is handled internally, and output emission is selectable.
//  Sits between the AES-CTR keystream/ciphertext path and tag generation in the GCM core.
// PARAMETERS
//  DIGIT     8  bits of X consumed per cycle; must divide 128 (1,2,4,8,16,32,64,128)
//  EMIT_ALL  0  1: emit Y after every block; 0: emit only on blocks flagged in_last
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    synchronous reset, active-low
//  in_valid   in   1    input block valid
//  in_ready   out  1    block accepted when in_valid & in_ready
//  in_x       in   128  [0:127] data block (AAD/ciphertext/length block)
//  in_h       in   128  [0:127] hash subkey H; sampled on accept
//  in_first   in   1    1: Y_prev = 0 (new message); 0: Y_prev = internal Y
//  in_last    in   1    final block of the message
//  out_valid  out  1    result valid; held until out_ready
//  out_ready  in   1    downstream accepts result
//  out_y      out  128  [0:127] Y_new
//  out_last   out  1    copy of in_last of the producing block
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE; in_ready=0 during reset, 1 in IDLE.
//    out_valid=0, out_y=0, out_last=0, internal Y=0, digit counter=0.
//  FSM: IDLE -> BUSY on accept. BUSY runs N=128/DIGIT cycles. BUSY -> OUT or IDLE. OUT -> IDLE.
//  IDLE: in_ready=1. On accept, latch the operands:
//    A = (in_first ? 0 : Y) ^ in_x
//    V = in_h, Z = 0, cnt = 0, last_q = in_last
//  BUSY: each cycle processes A bits [cnt*DIGIT +: DIGIT] in ascending index.
//    Per bit: if A[i], Z ^= V.
//    Then V = V[127] ? (V>>1) ^ R : (V>>1), where >>1 moves index i to i+1.
//    cnt increments each cycle; in_ready=0.
//  After the N-th BUSY cycle: Y <= Z.
//    If EMIT_ALL or last_q: out_y <= Z, out_last <= last_q, out_valid <= 1, go to OUT.
//    Otherwise go to IDLE.
//  Latency (accept to out_valid high) = N+1 cycles; DIGIT=8 gives 17.
//    Throughput = one block per N+1 cycles; no overlap of compute and output.
//  OUT: out_valid held and out_y stable until out_ready=1. The handshake clears out_valid -> IDLE.
//    in_ready=0 in OUT (no skid buffer); backpressure stalls the input.
//  Y is retained across messages but is ignored whenever in_first=1.
//    Y is not cleared by out handshake.
//  in_first=1 and in_last=1 together: single-block message, result = X*H.
//  Inputs are ignored unless in_valid&in_ready. Changes to in_h while BUSY have no effect.
//  Reset mid-BUSY or mid-OUT aborts the block: no output is produced.
//    The first accept after reset must carry in_first=1; otherwise Y=0 is used.
//  All arithmetic is XOR-only. No carries; widths fixed at 128.
// TESTING
//  Identity: H=8000..00, X=0123456789abcdeffedcba9876543210, first=last=1
//    -> out_y=X after 17 cycles (DIGIT=8).
//  Reduction: H=4000..00 (x), X=0000..0001 (bit127), first=last=1 -> out_y=e100..00.
//  Zero: X=0, any H=66e94bd4ef8a2c3b884cfa59ca342b2e -> out_y=0. Also X=any, H=0 -> 0.
//  Chaining: H=8000..00; blk1 X=0f..0f first=1 last=0; blk2 X=ff..ff first=0 last=1
//    -> single output f0..f0, out_last=1. With EMIT_ALL=1: two outputs 0f..0f, then f0..f0.
//  Backpressure: hold out_ready=0 for 10 cycles.
//    -> out_valid and out_y stable, in_ready=0 throughout; new block accepted one cycle after the out handshake.
//  Reset mid-BUSY at cycle 5: no out_valid.
//    Next block with first=1, H=8000..00, X=a5..a5 -> out_y=a5..a5.
//    Repeat all tests for DIGIT=1, 8, 128; latencies 129, 17, 2.

Source files
------------

// File: rtl/ghash_mult_seq_if.sv
// ghash_mult_seq_if: block-in / result-out handshake bundle for ghash_mult_seq
// master drives in_valid/in_x/in_h/in_first/in_last/out_ready; slave drives in_ready/out_valid/out_y/out_last
// in_x, in_h and out_y are [0:127]; bit 0 is the x^0 coefficient (GCM bit order)
interface ghash_mult_seq_if;
    logic         in_valid, in_ready, in_first, in_last;
    logic         out_valid, out_ready, out_last;
    logic [0:127] in_x, in_h, out_y;
    modport master (
        output in_valid, in_x, in_h, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_last
    );
    modport slave (
        input  in_valid, in_x, in_h, in_first, in_last, out_ready,
        output in_ready, out_valid, out_y, out_last
    );
endinterface

// File: rtl/ghash_mult_seq.sv
// ghash_mult_seq: digit-serial GF(2^128) multiplier with GHASH accumulator, Y = (Y ^ X) * H in GCM bit order
// clk: rising-edge clock; rst_n: synchronous active-low reset
// bus (slave): in_valid/in_ready accept a block (in_x, in_h, in_first, in_last);
//              out_valid/out_ready deliver out_y and out_last
// DIGIT bits of X are consumed per cycle (must divide 128); EMIT_ALL=1 emits every block, else only last blocks
module ghash_mult_seq #(
    parameter int DIGIT    = 8,
    parameter bit EMIT_ALL = 1'b0
) (
    input logic clk,
    input logic rst_n,
    ghash_mult_seq_if.slave bus
);
    localparam int N  = 128 / DIGIT;
    localparam int CW = $clog2(N + 1);
    localparam logic [0:127] R = {8'he1, 120'h0};
    typedef enum logic [1:0] {IDLE, BUSY, OUT} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [0:127]  a, v, z, y, z_n, v_n;
    logic          last_q;
    // a is shifted toward index 0 each cycle, so the current digit always sits in a[0:DIGIT-1]
    always_comb begin
        z_n = z;
        v_n = v;
        for (int i = 0; i < DIGIT; i++) begin
            z_n = a[i] ? z_n ^ v_n : z_n;
            v_n = v_n[127] ? {1'b0, v_n[0:126]} ^ R : {1'b0, v_n[0:126]};
        end
    end
    assign bus.in_ready = rst_n && state == IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            a             <= '0;
            v             <= '0;
            z             <= '0;
            y             <= '0;
            last_q        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_y     <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a      <= (bus.in_first ? '0 : y) ^ bus.in_x;
                    v      <= bus.in_h;
                    z      <= '0;
                    cnt    <= '0;
                    last_q <= bus.in_last;
                    state  <= BUSY;
                end
                BUSY: begin
                    z   <= z_n;
                    v   <= v_n;
                    a   <= a << DIGIT;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        y <= z_n;
                        if (EMIT_ALL || last_q) begin
                            bus.out_y     <= z_n;
                            bus.out_last  <= last_q;
                            bus.out_valid <= 1'b1;
                            state         <= OUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ghash_mult_seq.sv
// tb_ghash_mult_seq: scoreboard bench running every scenario on DIGIT=1/8/128 (EMIT_ALL=0) and DIGIT=8 (EMIT_ALL=1)
module tb_ghash_mult_seq;
    localparam int DIGS [4] = '{1, 8, 128, 8};
    localparam bit EMS  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [0:127] R   = {8'he1, 120'h0};
    localparam logic [0:127] ONE = {1'b1, 127'h0};
    typedef struct packed {
        logic [0:127] y;
        logic         last;
    } exp_t;
    logic         clk = 1'b0;
    logic [3:0]   rst_n, in_valid, in_first, in_last, out_ready;
    logic [3:0]   in_ready, out_valid, out_last;
    logic [0:127] in_x [4];
    logic [0:127] in_h [4];
    logic [0:127] out_y [4];
    logic [0:127] ymod [4];
    exp_t         sb [$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : u
        ghash_mult_seq_if bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.in_x      = in_x[g];
        assign bus.in_h      = in_h[g];
        assign bus.in_first  = in_first[g];
        assign bus.in_last   = in_last[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign out_y[g]      = bus.out_y;
        assign out_last[g]   = bus.out_last;
        ghash_mult_seq #(.DIGIT(DIGS[g]), .EMIT_ALL(EMS[g])) dut (
            .clk  (clk),
            .rst_n(rst_n[g]),
            .bus  (bus.slave)
        );
    end

    // Reference GF(2^128) multiply, one bit of x per step in ascending index
    function automatic logic [0:127] gmul(logic [0:127] x, logic [0:127] h);
        logic [0:127] z = '0;
        logic [0:127] v = h;
        for (int i = 0; i < 128; i++) begin
            if (x[i]) z ^= v;
            v = v[127] ? (v >> 1) ^ R : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [0:127] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(int k, logic [0:127] x, logic [0:127] h, logic first, logic last);
        int t = 0;
        in_valid[k] = 1'b1;
        in_x[k]     = x;
        in_h[k]     = h;
        in_first[k] = first;
        in_last[k]  = last;
        while (!in_ready[k] && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready[k]) begin
            $display("FAIL accept_timeout dut%0d in_ready=%b required 1", k, in_ready[k]);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_x[k]     = ~x;
        in_h[k]     = ~h;
        in_first[k] = ~first;
        ymod[k]     = gmul((first ? '0 : ymod[k]) ^ x, h);
        if (EMS[k] || last) sb.push_back(exp_t'{ymod[k], last});
    endtask

    task automatic drain(int k, string name, output logic [0:127] y, output int lat);
        exp_t e;
        lat = 1;
        while (!out_valid[k] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        y = out_y[k];
        checks++;
        if (!out_valid[k]) begin
            $display("FAIL %s_timeout dut%0d out_valid=%b required 1", name, k, out_valid[k]);
            errors++;
        end else if (sb.size() == 0) begin
            $display("FAIL %s_unexpected dut%0d out_y=%h required no output", name, k, out_y[k]);
            errors++;
        end else begin
            e = sb.pop_front();
            if (out_y[k] !== e.y) begin
                $display("FAIL %s_y dut%0d got %h expected %h", name, k, out_y[k], e.y);
                errors++;
            end
            checks++;
            if (out_last[k] !== e.last) begin
                $display("FAIL %s_last dut%0d got %b expected %b", name, k, out_last[k], e.last);
                errors++;
            end
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset(int k);
        rst_n[k]     = 1'b0;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (in_ready[k] !== 1'b0) begin $display("FAIL reset_in_ready dut%0d got %b expected 0", k, in_ready[k]); errors++; end
        if (out_valid[k] !== 1'b0) begin $display("FAIL reset_out_valid dut%0d got %b expected 0", k, out_valid[k]); errors++; end
        if (out_y[k] !== '0) begin $display("FAIL reset_out_y dut%0d got %h expected 0", k, out_y[k]); errors++; end
        if (out_last[k] !== 1'b0) begin $display("FAIL reset_out_last dut%0d got %b expected 0", k, out_last[k]); errors++; end
        in_valid[k] = 1'b0;
        rst_n[k]    = 1'b1;
        ymod[k]     = '0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready[k] !== 1'b1) begin $display("FAIL idle_in_ready dut%0d got %b expected 1", k, in_ready[k]); errors++; end
    endtask

    task automatic test_identity(int k);
        logic [0:127] x = 128'h0123456789abcdeffedcba9876543210;
        logic [0:127] y;
        int lat;
        send(k, x, ONE, 1'b1, 1'b1);
        drain(k, "identity", y, lat);
        checks += 2;
        if (y !== x) begin $display("FAIL identity_const dut%0d got %h expected %h", k, y, x); errors++; end
        if (lat != 128 / DIGS[k] + 1) begin $display("FAIL latency dut%0d got %0d expected %0d", k, lat, 128 / DIGS[k] + 1); errors++; end
    endtask

    task automatic test_reduction(int k);
        logic [0:127] y;
        int lat;
        send(k, 128'h1, {2'b01, 126'h0}, 1'b1, 1'b1);
        drain(k, "reduction", y, lat);
        checks++;
        if (y !== R) begin $display("FAIL reduction_const dut%0d got %h expected %h", k, y, R); errors++; end
    endtask

    task automatic test_zero(int k);
        logic [0:127] y;
        int lat;
        send(k, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b1, 1'b1);
        drain(k, "zero_x", y, lat);
        checks++;
        if (y !== '0) begin $display("FAIL zero_x_const dut%0d got %h expected 0", k, y); errors++; end
        send(k, rnd(), '0, 1'b1, 1'b1);
        drain(k, "zero_h", y, lat);
        checks++;
        if (y !== '0) begin $display("FAIL zero_h_const dut%0d got %h expected 0", k, y); errors++; end
    endtask

    task automatic test_chain(int k);
        logic [0:127] y;
        int lat;
        bit seen = 0;
        send(k, {16{8'h0f}}, ONE, 1'b1, 1'b0);
        if (EMS[k]) begin
            drain(k, "chain_mid", y, lat);
            checks++;
            if (y !== {16{8'h0f}}) begin $display("FAIL chain_mid_const dut%0d got %h expected %h", k, y, {16{8'h0f}}); errors++; end
        end else begin
            for (int i = 0; i < 128 / DIGS[k] + 3; i++) begin
                @(negedge clk);
                if (out_valid[k]) seen = 1;
            end
            checks++;
            if (seen) begin $display("FAIL chain_no_emit dut%0d out_valid=1 expected 0", k); errors++; end
        end
        send(k, {16{8'hff}}, ONE, 1'b0, 1'b1);
        drain(k, "chain_end", y, lat);
        checks++;
        if (y !== {16{8'hf0}}) begin $display("FAIL chain_end_const dut%0d got %h expected %h", k, y, {16{8'hf0}}); errors++; end
    endtask

    task automatic test_backpressure(int k);
        logic [0:127] y0, y;
        int lat, t = 0;
        bit stable = 1;
        out_ready[k] = 1'b0;
        send(k, rnd(), rnd(), 1'b1, 1'b1);
        while (!out_valid[k] && t < 400) begin
            @(negedge clk);
            t++;
        end
        y0 = out_y[k];
        in_valid[k] = 1'b1;
        in_x[k]     = rnd();
        in_first[k] = 1'b1;
        in_last[k]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid[k] || out_y[k] !== y0 || in_ready[k]) stable = 0;
        end
        checks++;
        if (!stable) begin $display("FAIL bp_stall dut%0d out_valid=%b out_y=%h in_ready=%b expected 1 %h 0", k, out_valid[k], out_y[k], in_ready[k], y0); errors++; end
        drain(k, "bp_first", y, lat);
        checks++;
        if (in_ready[k] !== 1'b1) begin $display("FAIL bp_ready_after dut%0d got %b expected 1", k, in_ready[k]); errors++; end
        send(k, rnd(), rnd(), 1'b1, 1'b1);
        drain(k, "bp_second", y, lat);
    endtask

    task automatic test_abort(int k);
        logic [0:127] y;
        int lat;
        bit seen = 0;
        send(k, rnd(), ONE, 1'b1, 1'b1);
        drain(k, "abort_pre", y, lat);
        send(k, rnd(), rnd(), 1'b1, 1'b1);
        for (int i = 0; i < (128 / DIGS[k] >= 5 ? 4 : 0); i++) begin
            @(negedge clk);
            if (out_valid[k]) seen = 1;
        end
        rst_n[k] = 1'b0;
        sb.delete();
        ymod[k] = '0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid[k]) seen = 1;
        end
        rst_n[k] = 1'b1;
        for (int i = 0; i < 128 / DIGS[k] + 3; i++) begin
            @(negedge clk);
            if (out_valid[k]) seen = 1;
        end
        checks++;
        if (seen) begin $display("FAIL abort_no_output dut%0d out_valid=1 expected 0", k); errors++; end
        send(k, {16{8'ha5}}, ONE, 1'b0, 1'b1);
        drain(k, "abort_y_cleared", y, lat);
        checks++;
        if (y !== {16{8'ha5}}) begin $display("FAIL abort_cleared_const dut%0d got %h expected %h", k, y, {16{8'ha5}}); errors++; end
        send(k, {16{8'ha5}}, ONE, 1'b1, 1'b1);
        drain(k, "abort_next", y, lat);
        checks++;
        if (y !== {16{8'ha5}}) begin $display("FAIL abort_next_const dut%0d got %h expected %h", k, y, {16{8'ha5}}); errors++; end
    endtask

    task automatic test_back_to_back(int k);
        logic [0:127] y, h;
        int lat;
        for (int m = 0; m < 3; m++) begin
            h = rnd();
            for (int b = 0; b <= m; b++) begin
                send(k, rnd(), h, b == 0, b == m);
                if (EMS[k] || b == m) drain(k, "b2b", y, lat);
            end
        end
        checks++;
        if (sb.size() != 0) begin $display("FAIL leftover dut%0d got %0d pending expected 0", k, sb.size()); errors++; end
    endtask

    initial begin
        rst_n     = '0;
        in_valid  = '0;
        in_first  = '0;
        in_last   = '0;
        out_ready = '1;
        for (int k = 0; k < 4; k++) begin
            in_x[k] = '0;
            in_h[k] = '0;
            ymod[k] = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            test_reset(k);
            test_identity(k);
            test_reduction(k);
            test_zero(k);
            test_chain(k);
            test_backpressure(k);
            test_abort(k);
            test_back_to_back(k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
